// File: rtl/dmem_responder.sv
// dmem_responder: Wishbone classic-cycle slave for the core's data-memory port.
// It decodes a fixed address window, waits a programmable number of cycles,
// then answers with ack (and a RAM read/write) on a hit or with err on a miss.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [3:0]              wcnt_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [15:0]             dat_reg;
    logic [1:0]              sel_reg;
    logic                    we_reg;
    logic                    hit_reg;

    // Halfword RAM; contents are deliberately not cleared by reset.
    logic [15:0]             mem [0:DEPTH-1];

    logic                    req;
    logic                    hit;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    unused_bits;

    assign req         = wb_cyc_i & wb_stb_i;
    assign hit         = (wb_adr_i[31:ADDR_WIDTH+1] == BASE_ADDR[31:ADDR_WIDTH+1]);
    assign req_idx     = wb_adr_i[ADDR_WIDTH:1];
    assign unused_bits = ^{wb_adr_i[0], wb_sel_i[3:2]};

    // The access that completes on this edge: taken live from the bus when
    // there are no wait states, otherwise from the fields latched in IDLE.
    logic                    enter_resp;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [15:0]             acc_dat;
    logic [1:0]              acc_sel;
    logic                    acc_we;
    logic                    acc_hit;
    logic                    mem_wr_en;

    // Select the completing access and decide whether RESP is entered now.
    always_comb begin
        enter_resp = 1'b0;
        acc_idx    = idx_reg;
        acc_dat    = dat_reg;
        acc_sel    = sel_reg;
        acc_we     = we_reg;
        acc_hit    = hit_reg;
        if (state_reg == S_IDLE) begin
            acc_idx    = req_idx;
            acc_dat    = wb_dat_i;
            acc_sel    = wb_sel_i[1:0];
            acc_we     = wb_we_i;
            acc_hit    = hit;
            enter_resp = req && (WS == 4'd0);
        end else if (state_reg == S_WAIT) begin
            // An abort (req low) wins over the final wait edge.
            enter_resp = req && (wcnt_reg == 4'd1);
        end
    end

    // Reset gates the write so a transfer caught by reset never lands in RAM.
    assign mem_wr_en = enter_resp && acc_hit && acc_we && !rst_i;

    // Byte-lane RAM write; only lanes selected by sel[1:0] are touched.
    always_ff @(posedge clk_i) begin
        for (int lane = 0; lane < 2; lane++) begin
            if (mem_wr_en && acc_sel[lane]) begin
                mem[acc_idx][lane*8 +: 8] <= acc_dat[lane*8 +: 8];
            end
        end
    end

    // Transfer FSM with registered ack/err and registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            wcnt_reg  <= 4'd0;
            idx_reg   <= '0;
            dat_reg   <= 16'h0000;
            sel_reg   <= 2'b00;
            we_reg    <= 1'b0;
            hit_reg   <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= 16'h0000;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (enter_resp) begin
                wb_ack_o <= acc_hit;
                wb_err_o <= !acc_hit;
                if (acc_hit && !acc_we) begin
                    wb_dat_o <= mem[acc_idx];
                end
            end
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        idx_reg  <= req_idx;
                        dat_reg  <= wb_dat_i;
                        sel_reg  <= wb_sel_i[1:0];
                        we_reg   <= wb_we_i;
                        hit_reg  <= hit;
                        wcnt_reg <= WS;
                        state_reg <= (WS == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_reg <= S_IDLE;
                    end else if (wcnt_reg == 4'd1) begin
                        state_reg <= S_RESP;
                    end else begin
                        wcnt_reg <= wcnt_reg - 4'd1;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 3 and 0 wait states) driven by
// a cycle-exact master; a transaction-level model predicts ack/err/data per cycle.
module tb_dmem_responder;

    localparam int NI = 3;

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 0;
    endfunction

    logic        clk = 1'b0;
    logic        rst    [NI];
    logic [31:0] adr    [NI];
    logic [15:0] dat_i  [NI];
    logic [15:0] dat_o  [NI];
    logic [3:0]  sel    [NI];
    logic        stb    [NI];
    logic        cyc    [NI];
    logic        we     [NI];
    logic        ack    [NI];
    logic        err    [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : gen_dut
        dmem_responder #(
            .ADDR_WIDTH (12),
            .WAIT_STATES((gi == 0) ? 1 : (gi == 1) ? 3 : 0),
            .BASE_ADDR  (32'h0000_0000)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst[gi]),
            .wb_adr_i(adr[gi]),
            .wb_dat_i(dat_i[gi]),
            .wb_dat_o(dat_o[gi]),
            .wb_sel_i(sel[gi]),
            .wb_stb_i(stb[gi]),
            .wb_cyc_i(cyc[gi]),
            .wb_we_i (we[gi]),
            .wb_ack_o(ack[gi]),
            .wb_err_o(err[gi])
        );
    end

    typedef struct {
        int          inst;
        int unsigned cyc;
        bit          ack;
        bit          err;
        bit          upd;
        logic [15:0] dat;
    } exp_t;

    exp_t        expq [$];
    logic [15:0] model_mem [NI][4096];
    logic [15:0] cur_dat   [NI];
    logic        prev_ack  [NI];
    int unsigned edge_n = 0;
    int          tests  = 0;
    int          fails  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, edge_n, act, exp);
        end
    endtask

    // Compare every instance's outputs against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic ea, ee;
            ea = 1'b0;
            ee = 1'b0;
            if (rst[i] === 1'b1) begin
                cur_dat[i] = 16'h0000;
            end else begin
                for (int q = 0; q < expq.size(); q++) begin
                    if (expq[q].inst == i && expq[q].cyc == edge_n) begin
                        ea = expq[q].ack;
                        ee = expq[q].err;
                        if (expq[q].upd) cur_dat[i] = expq[q].dat;
                    end
                end
            end
            chk("ack", i, 32'(ack[i]), 32'(ea));
            chk("err", i, 32'(err[i]), 32'(ee));
            chk("dat_o", i, 32'(dat_o[i]), 32'(cur_dat[i]));
            chk("ack_twice", i, 32'(ack[i] & prev_ack[i]), 32'd0);
            prev_ack[i] = ack[i];
        end
        for (int q = expq.size() - 1; q >= 0; q--) begin
            if (expq[q].cyc <= edge_n) expq.delete(q);
        end
    end

    task automatic preload(input int i, input int idx, input logic [15:0] v);
        case (i)
            0:       gen_dut[0].u_dut.mem[idx] = v;
            1:       gen_dut[1].u_dut.mem[idx] = v;
            default: gen_dut[2].u_dut.mem[idx] = v;
        endcase
        model_mem[i][idx] = v;
    endtask

    task automatic scramble(input int i);
        adr[i]   = $urandom;
        dat_i[i] = 16'($urandom);
        we[i]    = 1'($urandom_range(0, 1));
        sel[i]   = 4'($urandom);
    endtask

    // One transfer, entered and left right after a rising edge with the slave idle.
    task automatic xfer(input int i, input logic [31:0] a, input bit w, input logic [15:0] d,
                        input logic [3:0] s, input int abort_after, input bit hold);
        int          ws;
        int unsigned e;
        bit          hit;
        int          idx;
        exp_t        x;
        ws = ws_of(i);
        adr[i] = a; we[i] = w; dat_i[i] = d; sel[i] = s; cyc[i] = 1'b1; stb[i] = 1'b1;
        e = edge_n + 1;
        if (abort_after > 0) begin
            repeat (abort_after) begin
                @(posedge clk); #1;
                scramble(i);
            end
            stb[i] = 1'b0;
            cyc[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            $display("[TB] inst%0d E=%0d %s adr=%08h dat=%04h sel=%b aborted after %0d",
                     i, e, w ? "WR" : "RD", a, d, s, abort_after);
            return;
        end
        hit = ((a >> 13) == 32'd0);
        idx = int'((a >> 1) & 32'h0000_0FFF);
        x.inst = i; x.cyc = e + ws; x.ack = hit; x.err = !hit; x.upd = hit && !w; x.dat = 16'h0000;
        if (hit && w) begin
            if (s[0]) model_mem[i][idx] = (model_mem[i][idx] & 16'hFF00) | (d & 16'h00FF);
            if (s[1]) model_mem[i][idx] = (model_mem[i][idx] & 16'h00FF) | (d & 16'hFF00);
        end
        if (hit && !w) x.dat = model_mem[i][idx];
        expq.push_back(x);
        $display("[TB] inst%0d E=%0d %s adr=%08h dat=%04h sel=%b expect %s at cycle %0d",
                 i, e, w ? "WR" : "RD", a, hit && !w ? x.dat : d, s, hit ? "ack" : "err", x.cyc);
        for (int k = 0; k <= ws; k++) begin
            @(posedge clk); #1;
            if (k < ws) scramble(i);
        end
        if (!hold) begin
            stb[i] = 1'b0;
            cyc[i] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; adr[i] = '0; dat_i[i] = '0; sel[i] = '0;
            stb[i] = 1'b0; cyc[i] = 1'b0; we[i] = 1'b0;
            cur_dat[i] = 16'h0000; prev_ack[i] = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4096; k++) preload(i, k, 16'($urandom));
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("reset_dat_o", i, 32'(dat_o[i]), 32'h0000);
            chk("reset_ack", i, 32'(ack[i]), 32'd0);
            chk("reset_err", i, 32'(err[i]), 32'd0);
            rst[i] = 1'b0;
        end
        @(posedge clk); #1;

        // Write then read with one wait state.
        preload(0, 0, 16'hA5A5);
        xfer(0, 32'h0000_0010, 1'b1, 16'hBEEF, 4'b0011, 0, 1'b0);
        xfer(0, 32'h0000_0010, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("wr_rd_beef", 0, 32'(dat_o[0]), 32'h0000_BEEF);

        // Byte lanes.
        preload(0, 16, 16'hBEEF);
        xfer(0, 32'h0000_0020, 1'b1, 16'h12AA, 4'b0010, 0, 1'b0);
        xfer(0, 32'h0000_0020, 1'b0, 16'h0000, 4'b0000, 0, 1'b0);
        chk("lane_hi_only", 0, 32'(dat_o[0]), 32'h0000_12EF);
        xfer(0, 32'h0000_0020, 1'b1, 16'h0000, 4'b0000, 0, 1'b0);
        xfer(0, 32'h0000_0020, 1'b0, 16'h0000, 4'b1111, 0, 1'b0);
        chk("lane_none", 0, 32'(dat_o[0]), 32'h0000_12EF);

        // Out of window: err, RAM untouched, read data held.
        xfer(0, 32'h0001_0000, 1'b1, 16'h5555, 4'b0011, 0, 1'b0);
        xfer(0, 32'h0001_0000, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("miss_holds_dat", 0, 32'(dat_o[0]), 32'h0000_12EF);
        xfer(0, 32'h0000_0000, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("miss_no_alias_wr", 0, 32'(dat_o[0]), 32'h0000_A5A5);

        // Abort with three wait states.
        preload(1, 32, 16'h0BAD);
        xfer(1, 32'h0000_0040, 1'b1, 16'h1234, 4'b0011, 1, 1'b0);
        xfer(1, 32'h0000_0040, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("abort_no_write", 1, 32'(dat_o[1]), 32'h0000_0BAD);

        // Reset during the wait of a write.
        preload(1, 40, 16'hC0DE);
        adr[1] = 32'h0000_0050; dat_i[1] = 16'h7777; sel[1] = 4'b0011; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        #1;
        chk("rst_async_dat", 1, 32'(dat_o[1]), 32'h0000);
        chk("rst_async_ack", 1, 32'(ack[1]), 32'd0);
        chk("rst_async_err", 1, 32'(err[1]), 32'd0);
        stb[1] = 1'b0; cyc[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        xfer(1, 32'h0000_0050, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("rst_drops_write", 1, 32'(dat_o[1]), 32'h0000_C0DE);

        // Back-to-back reads with no wait states, strobe held throughout.
        preload(2, 8, 16'h1111);
        preload(2, 9, 16'h2222);
        xfer(2, 32'h0000_0010, 1'b0, 16'h0000, 4'b0011, 0, 1'b1);
        chk("b2b_first", 2, 32'(dat_o[2]), 32'h0000_1111);
        xfer(2, 32'h0000_0012, 1'b0, 16'h0000, 4'b0011, 0, 1'b0);
        chk("b2b_second", 2, 32'(dat_o[2]), 32'h0000_2222);

        // Randomized traffic on every instance.
        for (int i = 0; i < NI; i++) begin
            bit prev_hold;
            prev_hold = 1'b0;
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                bit          w, h;
                int          ab;
                a = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(13, 31));
                w  = 1'($urandom_range(0, 1));
                ab = 0;
                if (ws_of(i) > 0 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, ws_of(i));
                h = (n < 39) && ($urandom_range(0, 2) == 0);
                if (!prev_hold) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                xfer(i, a, w, 16'($urandom), 4'($urandom), ab, h);
                prev_hold = h && (ab == 0);
            end
            stb[i] = 1'b0;
            cyc[i] = 1'b0;
        end

        repeat (4) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
